// File: rtl/cpu_isa_pkg.sv
// ISA definitions shared by the pipeline control blocks: opcodes, field slices
// and the producer/consumer register-usage rules.
package cpu_isa_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h6800_0000;
    localparam logic [3:0]  RA_IDX    = 4'd15;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b00001,
        OP_MUL  = 5'b00010,
        OP_DIV  = 5'b00011,
        OP_MOD  = 5'b00100,
        OP_CMP  = 5'b00101,
        OP_AND  = 5'b00110,
        OP_OR   = 5'b00111,
        OP_NOT  = 5'b01000,
        OP_MOV  = 5'b01001,
        OP_LSL  = 5'b01010,
        OP_LSR  = 5'b01011,
        OP_ASR  = 5'b01100,
        OP_NOP  = 5'b01101,
        OP_LD   = 5'b01110,
        OP_ST   = 5'b01111,
        OP_BEQ  = 5'b10000,
        OP_BGT  = 5'b10001,
        OP_B    = 5'b10010,
        OP_CALL = 5'b10011,
        OP_RET  = 5'b10100
    } opcode_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MA   = 2'b01,
        FWD_RW   = 2'b10
    } fwd_sel_e;

    function automatic opcode_e opcode_of(input logic [31:0] instr);
        return opcode_e'(instr[31:27]);
    endfunction

    function automatic logic imm_of(input logic [31:0] instr);
        return instr[26];
    endfunction

    function automatic logic [3:0] rd_of(input logic [31:0] instr);
        return instr[25:22];
    endfunction

    function automatic logic [3:0] rs1_of(input logic [31:0] instr);
        return instr[21:18];
    endfunction

    function automatic logic [3:0] rs2_of(input logic [31:0] instr);
        return instr[17:14];
    endfunction

    function automatic logic writes_dest(input logic [31:0] instr);
        case (opcode_of(instr))
            OP_NOP, OP_CMP, OP_ST, OP_B, OP_BEQ, OP_BGT, OP_RET: return 1'b0;
            default:                                             return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] dest_of(input logic [31:0] instr);
        return (opcode_of(instr) == OP_CALL) ? RA_IDX : rd_of(instr);
    endfunction

    // ret reads the link register implicitly, so its rs1 field is ignored.
    function automatic logic [3:0] src_a_of(input logic [31:0] instr, output logic valid);
        case (opcode_of(instr))
            OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_NOT, OP_MOV: valid = 1'b0;
            default:                                               valid = 1'b1;
        endcase
        return (opcode_of(instr) == OP_RET) ? RA_IDX : rs1_of(instr);
    endfunction

    function automatic logic [3:0] src_b_of(input logic [31:0] instr, output logic valid);
        valid = !imm_of(instr) && (instr[31:27] <= OP_ASR);
        return rs2_of(instr);
    endfunction

endpackage

// File: rtl/stage_conflict_check.sv
// Compares the destination of an older (producer) instruction against the
// sources of a younger (consumer) instruction.
module stage_conflict_check
    import cpu_isa_pkg::*;
(
    input  logic [31:0] instr_producer_i,
    input  logic [31:0] instr_consumer_i,
    output logic        hit_a_o,
    output logic        hit_b_o,
    output logic        hit_st_o
);

    logic       a_valid;
    logic       b_valid;
    logic [3:0] a_idx;
    logic [3:0] b_idx;
    logic [3:0] dest;
    logic       wr;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        hit_a_o  = 1'b0;
        hit_b_o  = 1'b0;
        hit_st_o = 1'b0;

        wr    = writes_dest(instr_producer_i);
        dest  = dest_of(instr_producer_i);
        a_idx = src_a_of(instr_consumer_i, a_valid);
        b_idx = src_b_of(instr_consumer_i, b_valid);

        if (wr) begin
            hit_a_o  = a_valid && (a_idx == dest);
            hit_b_o  = b_valid && (b_idx == dest);
            hit_st_o = (opcode_of(instr_consumer_i) == OP_ST) && (rd_of(instr_consumer_i) == dest);
        end
    end

endmodule

// File: rtl/operand_forwarding_unit.sv
// Pipeline latch tracking for OF/EX/MA/RW with load-use bubbles, branch flushes
// and the operand forwarding mux selects for the datapath.
module operand_forwarding_unit
    import cpu_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_instr,
    input  logic        stall_in,
    input  logic        flush,
    output logic        fetch_ready,
    output logic [31:0] of_instr,
    output logic [31:0] ex_instr,
    output logic [31:0] ma_instr,
    output logic [31:0] rw_instr,
    output logic        load_use_stall,
    output logic        fwd_of_a_sel,
    output logic        fwd_of_b_sel,
    output logic [1:0]  fwd_ex_a_sel,
    output logic [1:0]  fwd_ex_b_sel,
    output logic        fwd_ma_st_sel
);

    logic [31:0] of_q, ex_q, ma_q, rw_q;
    logic [31:0] of_d, ex_d, ma_d, rw_d;

    logic ma_ex_a, ma_ex_b, ma_ex_st;
    logic rw_ex_a, rw_ex_b, rw_ex_st;
    logic rw_ma_a, rw_ma_b, rw_ma_st;
    logic rw_of_a, rw_of_b, rw_of_st;
    logic ex_of_a, ex_of_b, ex_of_st;
    logic ma_is_ld, ex_is_ld;
    logic unused_hits;

    stage_conflict_check u_ma_ex (
        .instr_producer_i (ma_q),
        .instr_consumer_i (ex_q),
        .hit_a_o          (ma_ex_a),
        .hit_b_o          (ma_ex_b),
        .hit_st_o         (ma_ex_st)
    );

    stage_conflict_check u_rw_ex (
        .instr_producer_i (rw_q),
        .instr_consumer_i (ex_q),
        .hit_a_o          (rw_ex_a),
        .hit_b_o          (rw_ex_b),
        .hit_st_o         (rw_ex_st)
    );

    stage_conflict_check u_rw_ma (
        .instr_producer_i (rw_q),
        .instr_consumer_i (ma_q),
        .hit_a_o          (rw_ma_a),
        .hit_b_o          (rw_ma_b),
        .hit_st_o         (rw_ma_st)
    );

    stage_conflict_check u_rw_of (
        .instr_producer_i (rw_q),
        .instr_consumer_i (of_q),
        .hit_a_o          (rw_of_a),
        .hit_b_o          (rw_of_b),
        .hit_st_o         (rw_of_st)
    );

    stage_conflict_check u_ex_of (
        .instr_producer_i (ex_q),
        .instr_consumer_i (of_q),
        .hit_a_o          (ex_of_a),
        .hit_b_o          (ex_of_b),
        .hit_st_o         (ex_of_st)
    );

    // Store data already reaches MA through the rd-field path, and MA itself
    // only consumes store data, so these pair results have no datapath user.
    assign unused_hits = ^{ma_ex_st, rw_ex_st, rw_ma_a, rw_ma_b, rw_of_st};

    assign ma_is_ld = (opcode_of(ma_q) == OP_LD);
    assign ex_is_ld = (opcode_of(ex_q) == OP_LD);

    assign load_use_stall = ex_is_ld && (ex_of_a || ex_of_b || ex_of_st);
    assign fetch_ready    = !stall_in && !load_use_stall;

    assign fwd_of_a_sel  = rw_of_a;
    assign fwd_of_b_sel  = rw_of_b;
    assign fwd_ma_st_sel = rw_ma_st;

    // The youngest producer wins; a load in MA has no data yet and is never a source.
    always_comb begin
        fwd_ex_a_sel = FWD_NONE;
        fwd_ex_b_sel = FWD_NONE;
        if (ma_ex_a && !ma_is_ld) fwd_ex_a_sel = FWD_MA;
        else if (rw_ex_a)         fwd_ex_a_sel = FWD_RW;
        if (ma_ex_b && !ma_is_ld) fwd_ex_b_sel = FWD_MA;
        else if (rw_ex_b)         fwd_ex_b_sel = FWD_RW;
    end

    always_comb begin
        of_d = of_q;
        ex_d = ex_q;
        ma_d = ma_q;
        rw_d = rw_q;
        if (stall_in) begin
            of_d = of_q;
        end else if (flush) begin
            of_d = NOP_INSTR;
            ex_d = NOP_INSTR;
            ma_d = ex_q;
            rw_d = ma_q;
        end else if (load_use_stall) begin
            ex_d = NOP_INSTR;
            ma_d = ex_q;
            rw_d = ma_q;
        end else begin
            of_d = fetch_instr;
            ex_d = of_q;
            ma_d = ex_q;
            rw_d = ma_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            of_q <= NOP_INSTR;
            ex_q <= NOP_INSTR;
            ma_q <= NOP_INSTR;
            rw_q <= NOP_INSTR;
        end else begin
            // NOTE: non-blocking assignments so every latch samples the pre-edge values of the others.
            of_q <= of_d;
            ex_q <= ex_d;
            ma_q <= ma_d;
            rw_q <= rw_d;
        end
    end

    assign of_instr = of_q;
    assign ex_instr = ex_q;
    assign ma_instr = ma_q;
    assign rw_instr = rw_q;

endmodule

// File: tb/tb_operand_forwarding_unit.sv
// Directed bench for operand_forwarding_unit: hazards, forwarding selects,
// flush/stall priority and asynchronous reset.
module tb_operand_forwarding_unit;

    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] SUB  = 5'b00001;
    localparam logic [4:0] MUL  = 5'b00010;
    localparam logic [4:0] CMP  = 5'b00101;
    localparam logic [4:0] AND_ = 5'b00110;
    localparam logic [4:0] OR_  = 5'b00111;
    localparam logic [4:0] LD   = 5'b01110;
    localparam logic [4:0] ST   = 5'b01111;
    localparam logic [4:0] CALL = 5'b10011;
    localparam logic [4:0] RET  = 5'b10100;
    localparam logic [31:0] NOP = 32'h6800_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_instr;
    logic        stall_in;
    logic        flush;
    logic        fetch_ready;
    logic [31:0] of_instr, ex_instr, ma_instr, rw_instr;
    logic        load_use_stall;
    logic        fwd_of_a_sel, fwd_of_b_sel;
    logic [1:0]  fwd_ex_a_sel, fwd_ex_b_sel;
    logic        fwd_ma_st_sel;

    int checks = 0;
    int errors = 0;

    operand_forwarding_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_instr    (fetch_instr),
        .stall_in       (stall_in),
        .flush          (flush),
        .fetch_ready    (fetch_ready),
        .of_instr       (of_instr),
        .ex_instr       (ex_instr),
        .ma_instr       (ma_instr),
        .rw_instr       (rw_instr),
        .load_use_stall (load_use_stall),
        .fwd_of_a_sel   (fwd_of_a_sel),
        .fwd_of_b_sel   (fwd_of_b_sel),
        .fwd_ex_a_sel   (fwd_ex_a_sel),
        .fwd_ex_b_sel   (fwd_ex_b_sel),
        .fwd_ma_st_sel  (fwd_ma_st_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic imm,
                                        input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [3:0] rs2);
        return {op, imm, rd, rs1, rs2, 14'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr);
        fetch_instr = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) push(NOP);
    endtask

    task automatic check_latches(input string tag, input logic [31:0] e_of, input logic [31:0] e_ex,
                                 input logic [31:0] e_ma, input logic [31:0] e_rw);
        check({tag, "_of"}, of_instr, e_of);
        check({tag, "_ex"}, ex_instr, e_ex);
        check({tag, "_ma"}, ma_instr, e_ma);
        check({tag, "_rw"}, rw_instr, e_rw);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a1, a2, s6, ld2, a3, a7, st7, ld7, call_i, ret_i;
        logic [31:0] p1, p2, p3, p4, p5, pc, cmp_i, c1;

        a1     = enc(ADD, 1'b0, 4'd1, 4'd2, 4'd3);
        a2     = enc(ADD, 1'b0, 4'd4, 4'd1, 4'd5);
        s6     = enc(SUB, 1'b0, 4'd6, 4'd1, 4'd1);
        ld2    = enc(LD,  1'b1, 4'd2, 4'd3, 4'd0);
        a3     = enc(ADD, 1'b0, 4'd4, 4'd2, 4'd5);
        a7     = enc(ADD, 1'b0, 4'd7, 4'd1, 4'd2);
        st7    = enc(ST,  1'b1, 4'd7, 4'd8, 4'd0);
        ld7    = enc(LD,  1'b1, 4'd7, 4'd3, 4'd0);
        call_i = enc(CALL, 1'b1, 4'd0, 4'd0, 4'd0);
        ret_i  = enc(RET, 1'b0, 4'd0, 4'd0, 4'd0);
        p1     = enc(ADD, 1'b0, 4'd1, 4'd2, 4'd3);
        p2     = enc(SUB, 1'b0, 4'd1, 4'd4, 4'd5);
        pc     = enc(ADD, 1'b0, 4'd9, 4'd1, 4'd0);
        cmp_i  = enc(CMP, 1'b0, 4'd1, 4'd2, 4'd3);
        c1     = enc(ADD, 1'b0, 4'd4, 4'd1, 4'd1);
        p3     = enc(MUL, 1'b0, 4'd8, 4'd9, 4'd10);
        p4     = enc(OR_, 1'b0, 4'd11, 4'd12, 4'd13);
        p5     = enc(AND_, 1'b0, 4'd14, 4'd2, 4'd3);

        rst_n = 1'b1; stall_in = 1'b0; flush = 1'b0; fetch_instr = NOP;
        #2 rst_n = 1'b0;
        #2;
        check_latches("reset", NOP, NOP, NOP, NOP);
        check("reset_lus", {31'b0, load_use_stall}, 32'd0);
        check("reset_ex_a", {30'b0, fwd_ex_a_sel}, 32'd0);
        check("reset_of_a", {31'b0, fwd_of_a_sel}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rel_fetch_ready", {31'b0, fetch_ready}, 32'd1);

        // add r1 -> add r4,r1,r5: MA forwarding one stage later
        push(a1);
        push(a2);
        check("add_early_ex_a", {30'b0, fwd_ex_a_sel}, 32'd0);
        check("add_early_of_a", {31'b0, fwd_of_a_sel}, 32'd0);
        check("add_early_lus", {31'b0, load_use_stall}, 32'd0);
        push(NOP);
        check("add_ex_a_ma", {30'b0, fwd_ex_a_sel}, 32'd1);
        check("add_ex_b", {30'b0, fwd_ex_b_sel}, 32'd0);
        drain();

        // add r1, nop, nop, sub r6,r1,r1: RW -> OF on both operands
        push(a1); push(NOP); push(NOP); push(s6);
        check("sub_of_a", {31'b0, fwd_of_a_sel}, 32'd1);
        check("sub_of_b", {31'b0, fwd_of_b_sel}, 32'd1);
        drain();

        // ld r2 then add r4,r2,r5: one bubble then RW forwarding
        push(ld2);
        push(a3);
        check("lu_stall", {31'b0, load_use_stall}, 32'd1);
        check("lu_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        push(NOP);
        check_latches("lu_bubble", a3, NOP, ld2, NOP);
        check("lu_stall_off", {31'b0, load_use_stall}, 32'd0);
        check("lu_fetch_ready_on", {31'b0, fetch_ready}, 32'd1);
        push(NOP);
        check("lu_ex_a_rw", {30'b0, fwd_ex_a_sel}, 32'd2);
        drain();

        // add r7 then st r7,[r8]
        push(a7); push(st7);
        check("st_of_lus", {31'b0, load_use_stall}, 32'd0);
        push(NOP);
        check("st_ex_a", {30'b0, fwd_ex_a_sel}, 32'd0);
        check("st_ex_b", {30'b0, fwd_ex_b_sel}, 32'd0);
        push(NOP);
        check("st_ma_sel", {31'b0, fwd_ma_st_sel}, 32'd1);
        drain();

        // ld r7 then st r7: store data counts as a load-use source
        push(ld7); push(st7);
        check("ld_st_lus", {31'b0, load_use_stall}, 32'd1);
        push(NOP);
        check("ld_st_lus_off", {31'b0, load_use_stall}, 32'd0);
        drain();

        // call in RW, ret in OF
        push(call_i); push(NOP); push(NOP); push(ret_i);
        check("ret_of_a", {31'b0, fwd_of_a_sel}, 32'd1);
        drain();

        // two producers of r1: MA must win over RW
        push(p1); push(p2); push(pc); push(NOP);
        check("prio_ex_a", {30'b0, fwd_ex_a_sel}, 32'd1);
        drain();

        // cmp does not write r1
        push(cmp_i); push(c1); push(NOP);
        check("cmp_ex_a", {30'b0, fwd_ex_a_sel}, 32'd0);
        check("cmp_ex_b", {30'b0, fwd_ex_b_sel}, 32'd0);
        push(NOP);
        check("cmp_ma_st", {31'b0, fwd_ma_st_sel}, 32'd0);
        drain();

        // stall + flush: everything holds; flush alone: OF/EX killed
        push(p1); push(p2); push(p3); push(p4);
        check_latches("fill", p4, p3, p2, p1);
        stall_in = 1'b1; flush = 1'b1; fetch_instr = p5;
        #1;
        check("stall_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        @(posedge clk); #1;
        check_latches("stall_flush", p4, p3, p2, p1);
        stall_in = 1'b0;
        #1;
        check("flush_fetch_ready", {31'b0, fetch_ready}, 32'd1);
        @(posedge clk); #1;
        check_latches("flush", NOP, NOP, p3, p2);
        flush = 1'b0;
        push(p5);
        check("after_flush_of", of_instr, p5);

        // asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        check_latches("mid_reset", NOP, NOP, NOP, NOP);
        rst_n = 1'b1;
        #1;
        check("mid_reset_fetch_ready", {31'b0, fetch_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_forwarding_unit.md
Name: operand_forwarding_unit

Overview:
- Tracks the instruction words held in the OF, EX, MA and RW pipeline latches.
- Inserts bubbles on load-use hazards and on branch flushes.
- Drives the per-stage operand forwarding mux selects for the datapath.
- Sits between fetch and the datapath. Each stage pair is checked with the shared producer/consumer conflict rule.

Parameters:
- NOP_INSTR, 32'h6800_0000, bubble word (opcode nop) loaded on reset, flush and load-use bubble.
- RA_IDX, 4'd15, return-address register index (implicit dest of call, implicit src of ret).

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- fetch_instr  input  32  instruction from IF, consumed when fetch_ready=1
- stall_in  input  1  external freeze (multicycle div/mod); holds every latch
- flush  input  1  branch taken, resolved in EX; kills OF and EX contents
- fetch_ready  output  1  IF may advance this cycle
- of_instr, ex_instr, ma_instr, rw_instr  output  32 each  current latch contents
- load_use_stall  output  1  bubble being inserted into EX this cycle
- fwd_of_a_sel, fwd_of_b_sel  output  1 each  OF operand A/B taken from RW result
- fwd_ex_a_sel, fwd_ex_b_sel  output  2 each  00 register file / latch, 01 MA result, 10 RW result
- fwd_ma_st_sel  output  1  MA store data taken from RW result

Behaviour:
- Reset (async, rst_n=0): all four latches = NOP_INSTR; all selects 0; load_use_stall=0; fetch_ready=1 after release.
- Field decode: opcode [31:27], I [26], rd [25:22], rs1 [21:18], rs2 [17:14].
- Producer writes dest:
  - Every opcode writes a dest except nop, cmp, st, b, beq, bgt, ret.
  - call writes RA_IDX; all others write rd.
- Consumer source A (rs1): read by every opcode except nop, b, beq, bgt, call, not, mov; ret reads RA_IDX.
- Consumer source B (rs2): read only when I=0 and opcode is add..asr (00000-01100).
- st data source: rd field of st is a source, used for the MA store-data check only.
- Load-use: load_use_stall=1 when ex_instr is ld and its rd matches an active source A/B of of_instr, or the rd (data) field of an st in OF. Combinational.
- Update priority per rising edge, highest first:
  - stall_in=1: all latches hold.
  - flush=1: OF<=NOP_INSTR, EX<=NOP_INSTR, MA<=EX, RW<=MA; fetch_instr is dropped.
  - load_use_stall=1: OF holds, EX<=NOP_INSTR, MA<=EX, RW<=MA.
  - Otherwise: OF<=fetch_instr, EX<=OF, MA<=EX, RW<=MA.
- fetch_ready = !stall_in && !load_use_stall (1 during flush; IF redirects).
- Selects are combinational from the current latches:
  - fwd_ex_x_sel: MA wins over RW when both conflict (youngest producer first).
  - A ld in MA is never a forwarding source for EX (data not yet available). Load-use stalls prevent that case, and the check explicitly excludes it.
  - fwd_ma_st_sel: st in MA whose rd field equals the RW producer dest.
  - fwd_of_x_sel: RW producer vs OF sources.
- NOP_INSTR latches never produce or consume, so bubbles never cause forwarding.
- Reset asserted mid-stream: all latches go to NOP_INSTR immediately; no partial state survives.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - opcode constants for all 21 opcodes, NOP_INSTR and RA_IDX;
  - field slice helpers;
  - functions writes_dest(instr), dest_of(instr), src_a_of(instr, valid), src_b_of(instr, valid).
- One sub-module: stage_conflict_check (instr_producer, instr_consumer -> hit_a, hit_b, hit_st). Instantiate it once per checked stage pair: MA->EX, RW->EX, RW->MA, RW->OF, EX->OF for load-use.

Test Plan:
- Reset release, fetch add r1,r2,r3 then add r4,r1,r5 -> when the second add is in EX, fwd_ex_a_sel=01; one cycle earlier, no selects active.
- add r1 then two nops then sub r6,r1,r1 -> sub in OF with add in RW gives fwd_of_a_sel=1 and fwd_of_b_sel=1.
- ld r2,[r3] followed by add r4,r2,r5 -> load_use_stall=1 and fetch_ready=0 for exactly 1 cycle; EX gets 32'h6800_0000; next cycle fwd_ex_a_sel=10.
- add r7,.. then st r7,[r8] adjacent -> sequence: fwd_ex_b_sel stays 00 (st uses imm); fwd_ex_a_sel=00 (src is r8); fwd_ma_st_sel=1 when st is in MA and add is in RW.
- call in RW, ret in OF -> fwd_of_a_sel=1 (RA_IDX match); cmp r1,.. producer with any consumer of r1 -> all selects 0.
- flush and stall_in asserted together -> latches hold. flush alone -> OF and EX become NOP_INSTR, MA/RW advance. rst_n pulsed mid-stream -> all latches NOP_INSTR asynchronously.
